seg14_scan_decoder: RTL

//  Receive end of the 12-digit 14-segment multiplexed display bus. Snoops sel/segm as driven by the

---
 rtl/seg14_pkg.sv | 52 +++++
 rtl/seg14_scan_decoder_if.sv | 30 +++
 rtl/seg14_glyph_decode.sv | 58 +++++
 rtl/seg14_scan_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment scan decoder: glyph table, ASCII constants, streamer states.
// Segment order, MSB first: a b c d e f g1 g2 h(TL diag) i(top mid) j(TR diag) k(BR diag) l(bot mid) m(BL diag).
package seg14_pkg;

  localparam int SEG14_DIGITS = 12;
  localparam int SEG14_SEG_W  = 14;
  localparam int SEG14_CHAR_W = 8;

  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [13:0] GLYPH_SPACE = 14'b00000000000000;
  localparam logic [13:0] GLYPH_A = 14'b11101111000000;
  localparam logic [13:0] GLYPH_B = 14'b11110001010010;
  localparam logic [13:0] GLYPH_C = 14'b10011100000000;
  localparam logic [13:0] GLYPH_D = 14'b11110000010010;
  localparam logic [13:0] GLYPH_E = 14'b10011110000000;
  localparam logic [13:0] GLYPH_F = 14'b10001110000000;
  localparam logic [13:0] GLYPH_G = 14'b10111101000000;
  localparam logic [13:0] GLYPH_H = 14'b01101111000000;
  localparam logic [13:0] GLYPH_I = 14'b10010000010010;
  localparam logic [13:0] GLYPH_J = 14'b01111000000000;
  localparam logic [13:0] GLYPH_K = 14'b00001110001100;
  localparam logic [13:0] GLYPH_L = 14'b00011100000000;
  localparam logic [13:0] GLYPH_M = 14'b01101100101000;
  localparam logic [13:0] GLYPH_N = 14'b01101100100100;
  localparam logic [13:0] GLYPH_O = 14'b11111100000000;
  localparam logic [13:0] GLYPH_P = 14'b11001111000000;
  localparam logic [13:0] GLYPH_Q = 14'b11111100000100;
  localparam logic [13:0] GLYPH_R = 14'b11001111000100;
  localparam logic [13:0] GLYPH_S = 14'b10110111000000;
  localparam logic [13:0] GLYPH_T = 14'b10000000010010;
  localparam logic [13:0] GLYPH_U = 14'b01111100000000;
  localparam logic [13:0] GLYPH_V = 14'b00001100001001;
  localparam logic [13:0] GLYPH_W = 14'b01101100000101;
  localparam logic [13:0] GLYPH_X = 14'b00000000101101;
  localparam logic [13:0] GLYPH_Y = 14'b00000000101010;
  localparam logic [13:0] GLYPH_Z = 14'b10010000001001;
  localparam logic [13:0] GLYPH_0 = 14'b11111100001001;
  localparam logic [13:0] GLYPH_1 = 14'b01100000001000;
  localparam logic [13:0] GLYPH_2 = 14'b11011011000000;
  localparam logic [13:0] GLYPH_3 = 14'b11110001000000;
  localparam logic [13:0] GLYPH_4 = 14'b01100111000000;
  localparam logic [13:0] GLYPH_5 = 14'b10110111000000;
  localparam logic [13:0] GLYPH_6 = 14'b10111111000000;
  localparam logic [13:0] GLYPH_7 = 14'b11100000000000;
  localparam logic [13:0] GLYPH_8 = 14'b11111111000000;
  localparam logic [13:0] GLYPH_9 = 14'b11110111000000;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} stream_state_e;

endpackage

// File: rtl/seg14_scan_decoder_if.sv
// Snoop bus (sel/segm), output character stream and status flags of the scan decoder.
interface seg14_scan_decoder_if #(
  parameter int DIGITS = 12,
  parameter int SEG_W  = 14,
  parameter int CHAR_W = 8
);
  logic [DIGITS-1:0] sel;
  logic [SEG_W-1:0]  segm;
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] out_char;
  logic [3:0]        out_pos;
  logic              out_last;
  logic              frame_done;
  logic              seq_err;
  logic              unk_glyph;
  logic [15:0]       err_count;

  // Environment side: the display scanner plus the character sink.
  modport master (
    output sel, segm, out_ready,
    input  out_valid, out_char, out_pos, out_last, frame_done, seq_err, unk_glyph, err_count
  );

  // Decoder side.
  modport slave (
    input  sel, segm, out_ready,
    output out_valid, out_char, out_pos, out_last, frame_done, seq_err, unk_glyph, err_count
  );
endinterface

// File: rtl/seg14_glyph_decode.sv
// Combinational 14-segment pattern to ASCII lookup; any pattern outside the table yields '?'.
module seg14_glyph_decode
  import seg14_pkg::*;
(
  input  logic [13:0] segm_i,
  output logic [7:0]  ascii_o,
  output logic        unknown_o
);

  // Exact-match lookup; GLYPH_5 is identical to GLYPH_S and therefore decodes as the letter.
  always_comb begin
    ascii_o   = ASCII_QMARK;
    unknown_o = 1'b0;
    case (segm_i)
      GLYPH_SPACE: ascii_o = ASCII_SPACE;
      GLYPH_A: ascii_o = 8'h41;
      GLYPH_B: ascii_o = 8'h42;
      GLYPH_C: ascii_o = 8'h43;
      GLYPH_D: ascii_o = 8'h44;
      GLYPH_E: ascii_o = 8'h45;
      GLYPH_F: ascii_o = 8'h46;
      GLYPH_G: ascii_o = 8'h47;
      GLYPH_H: ascii_o = 8'h48;
      GLYPH_I: ascii_o = 8'h49;
      GLYPH_J: ascii_o = 8'h4A;
      GLYPH_K: ascii_o = 8'h4B;
      GLYPH_L: ascii_o = 8'h4C;
      GLYPH_M: ascii_o = 8'h4D;
      GLYPH_N: ascii_o = 8'h4E;
      GLYPH_O: ascii_o = 8'h4F;
      GLYPH_P: ascii_o = 8'h50;
      GLYPH_Q: ascii_o = 8'h51;
      GLYPH_R: ascii_o = 8'h52;
      GLYPH_S: ascii_o = 8'h53;
      GLYPH_T: ascii_o = 8'h54;
      GLYPH_U: ascii_o = 8'h55;
      GLYPH_V: ascii_o = 8'h56;
      GLYPH_W: ascii_o = 8'h57;
      GLYPH_X: ascii_o = 8'h58;
      GLYPH_Y: ascii_o = 8'h59;
      GLYPH_Z: ascii_o = 8'h5A;
      GLYPH_0: ascii_o = 8'h30;
      GLYPH_1: ascii_o = 8'h31;
      GLYPH_2: ascii_o = 8'h32;
      GLYPH_3: ascii_o = 8'h33;
      GLYPH_4: ascii_o = 8'h34;
      GLYPH_6: ascii_o = 8'h36;
      GLYPH_7: ascii_o = 8'h37;
      GLYPH_8: ascii_o = 8'h38;
      GLYPH_9: ascii_o = 8'h39;
      default: begin
        ascii_o   = ASCII_QMARK;
        unknown_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg14_scan_decoder.sv
// Rebuilds 12-character frames from the snooped sel/segm scan and streams each frame out.
// Optional saturating error counter: define SEG14_SCAN_ERR_CNT_EN.
module seg14_scan_decoder
  import seg14_pkg::*;
#(
  parameter int DIGITS = SEG14_DIGITS,
  parameter int SEG_W  = SEG14_SEG_W,
  parameter int CHAR_W = SEG14_CHAR_W
) (
  input logic                 clk,
  input logic                 rst_n,
  seg14_scan_decoder_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  logic [DIGITS-1:0] sel_q;
  logic [SEG_W-1:0]  segm_q;
  logic [7:0]        dec_char_s;
  logic              dec_unk_s;
  logic [4:0]        hot_cnt_s;
  logic [3:0]        hot_idx_s;

  logic [3:0]        exp_q, exp_d;
  logic              wr_en_s;
  logic              frame_done_q, frame_done_d;
  logic              seq_err_q, seq_err_d;
  logic              unk_q, unk_d;
  logic [CHAR_W-1:0] cap_q    [DIGITS];
  logic [CHAR_W-1:0] shadow_q [DIGITS];

  stream_state_e     state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              load_s, drop_s;

  // Stage 1: register the snooped bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      segm_q <= '0;
    end else begin
      sel_q  <= bus.sel;
      segm_q <= bus.segm;
    end
  end

  seg14_glyph_decode u_decode (
    .segm_i    (segm_q),
    .ascii_o   (dec_char_s),
    .unknown_o (dec_unk_s)
  );

  // Population count and index of the registered select.
  always_comb begin
    hot_cnt_s = 5'd0;
    hot_idx_s = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      hot_cnt_s = hot_cnt_s + {4'd0, sel_q[k]};
      hot_idx_s = hot_idx_s | (sel_q[k] ? 4'(k) : 4'd0);
    end
  end

  // Stage 2 classification: in-order write, restart on index 0, or discard.
  always_comb begin
    exp_d        = exp_q;
    wr_en_s      = 1'b0;
    frame_done_d = 1'b0;
    seq_err_d    = 1'b0;
    unk_d        = 1'b0;
    if (hot_cnt_s > 5'd1) begin
      seq_err_d = 1'b1;
      exp_d     = 4'd0;
    end else if (hot_cnt_s == 5'd1) begin
      if (hot_idx_s == exp_q) begin
        wr_en_s      = 1'b1;
        unk_d        = dec_unk_s;
        frame_done_d = (hot_idx_s == LAST_IDX);
        exp_d        = (hot_idx_s == LAST_IDX) ? 4'd0 : hot_idx_s + 4'd1;
      end else if (hot_idx_s == 4'd0) begin
        seq_err_d = 1'b1;
        wr_en_s   = 1'b1;
        unk_d     = dec_unk_s;
        exp_d     = 4'd1;
      end else begin
        seq_err_d = 1'b1;
        exp_d     = 4'd0;
      end
    end else begin
      exp_d = exp_q;
    end
  end

  // Capture buffer, expected index and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q        <= 4'd0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      unk_q        <= 1'b0;
      for (int k = 0; k < DIGITS; k++) cap_q[k] <= CHAR_W'(ASCII_SPACE);
    end else begin
      exp_q        <= exp_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      unk_q        <= unk_d;
      if (wr_en_s) begin
        cap_q[hot_idx_s] <= CHAR_W'(dec_char_s);
      end
    end
  end

  // Streamer next state: snapshot on frame_done, walk the shadow copy one handshake at a time.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    char_d  = char_q;
    last_d  = last_q;
    load_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_done_q) begin
          state_d = STREAM;
          load_s  = 1'b1;
          ptr_d   = 4'd0;
          valid_d = 1'b1;
          char_d  = cap_q[0];
          last_d  = (LAST_IDX == 4'd0);
        end else begin
          valid_d = 1'b0;
        end
      end
      STREAM: begin
        drop_s = frame_done_q;
        if (valid_q && bus.out_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = IDLE;
            ptr_d   = 4'd0;
            valid_d = 1'b0;
            char_d  = '0;
            last_d  = 1'b0;
          end else begin
            ptr_d  = ptr_q + 4'd1;
            char_d = shadow_q[ptr_q + 4'd1];
            last_d = ((ptr_q + 4'd1) == LAST_IDX);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = 4'd0;
        valid_d = 1'b0;
        char_d  = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Streamer state, output registers and frame shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      valid_q <= 1'b0;
      char_q  <= '0;
      last_q  <= 1'b0;
      for (int k = 0; k < DIGITS; k++) shadow_q[k] <= CHAR_W'(ASCII_SPACE);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      char_q  <= char_d;
      last_q  <= last_d;
      if (load_s) begin
        for (int k = 0; k < DIGITS; k++) shadow_q[k] <= cap_q[k];
      end
    end
  end

`ifdef SEG14_SCAN_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc_s;
  logic [16:0] err_sum_s;

  // One count per error event in the cycle, clamped at all-ones.
  always_comb begin
    err_inc_s = {1'b0, seq_err_q} + {1'b0, unk_q} + {1'b0, drop_s};
    err_sum_s = {1'b0, err_cnt_q} + {15'd0, err_inc_s};
    if (err_sum_s[16]) begin
      err_cnt_d = 16'hFFFF;
    end else begin
      err_cnt_d = err_sum_s[15:0];
    end
  end

  // Error counter register; cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 16'h0000;
`endif

  assign bus.out_valid  = valid_q;
  assign bus.out_char   = char_q;
  assign bus.out_pos    = ptr_q;
  assign bus.out_last   = last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.unk_glyph  = unk_q;

endmodule
